// File: rtl/stream_pkg.sv
// Shared definitions for the stream mux/demux family: lock FSM states and tag width helper.
package stream_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // Width of a channel index tag; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last accepted channel; hold pins the grant to it.
module rr_arbiter
    import stream_pkg::*;
#(
    parameter  int unsigned NUM_CH = 2,
    localparam int unsigned ID_W   = id_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    input  logic              hold,
    output logic [NUM_CH-1:0] grant_c,
    output logic [ID_W-1:0]   grant_idx_c
);

    logic [ID_W-1:0] ptr_q;
    logic            found;
    int unsigned     cand;

    // Pointer holds the last accepted channel; reset value gives channel 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= ID_W'(NUM_CH - 1);
        end else if (advance) begin
            ptr_q <= grant_idx_c;
        end
    end

    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        cand        = 0;
        if (hold) begin
            if (req[ptr_q]) begin
                grant_c[ptr_q] = 1'b1;
                grant_idx_c    = ptr_q;
            end
        end else begin
            for (int unsigned k = 1; k <= NUM_CH; k++) begin
                cand = (32'(ptr_q) + k) % NUM_CH;
                if (!found && req[ID_W'(cand)]) begin
                    found                 = 1'b1;
                    grant_c[ID_W'(cand)] = 1'b1;
                    grant_idx_c           = ID_W'(cand);
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 round-robin stream mux with a registered, channel-tagged output slot.
// Define STREAM_MUX_PKT_LOCK_EN to add in_last/out_last and hold the grant for a whole packet.
module stream_mux_rr
    import stream_pkg::*;
#(
    parameter  int unsigned NUM_CH = 2,
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned ID_W   = id_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [ID_W-1:0]          out_sel,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic [NUM_CH-1:0]        in_last,
    output logic                     out_last,
`endif
    input  logic                     out_ready
);

    logic              run_q;
    logic              slot_free;
    logic              accept;
    logic              hold;
    logic [NUM_CH-1:0] grant;
    logic [ID_W-1:0]   grant_idx;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (in_valid),
        .advance     (accept),
        .hold        (hold),
        .grant_c     (grant),
        .grant_idx_c (grant_idx)
    );

    // run_q keeps every in_ready low while reset is asserted and until the first edge after it.
    assign slot_free = run_q && (!out_valid || out_ready);
    assign accept    = slot_free && (|grant);
    assign in_ready  = {NUM_CH{slot_free}} & grant;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Single output register: reloads whenever the slot drains or is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else begin
            run_q <= 1'b1;
            if (slot_free) begin
                out_valid <= accept;
                if (accept) begin
                    out_data <= sel_data;
                    out_sel  <= grant_idx;
                end
            end
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_state_e state_q;
    logic        sel_last;

    assign sel_last = in_last[grant_idx];
    assign hold     = (state_q == LOCKED);

    // Lock FSM: a non-last word opens a packet, the last word releases the arbiter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB;
            out_last <= 1'b0;
        end else if (accept) begin
            out_last <= sel_last;
            case (state_q)
                ARB:     if (!sel_last) state_q <= LOCKED;
                LOCKED:  if (sel_last)  state_q <= ARB;
                default: state_q <= ARB;
            endcase
        end
    end
`else
    assign hold = 1'b0;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (NUM_CH=2, DATA_W=8); packet-lock checks when STREAM_MUX_PKT_LOCK_EN is defined.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  in_valid;
    logic [15:0] in_data;
    logic [1:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sel;
    logic        out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic [1:0]  in_last;
    logic        out_last;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.NUM_CH(2), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_ready (out_ready)
    );

    typedef struct {
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ordy;
        logic [1:0] exp_rdy;
        logic       exp_ov;
        logic [7:0] exp_data;
        logic       exp_sel;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive at negedge, check in_ready before the edge, check the output register after it.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        in_valid  = v.valid;
        in_data   = {v.d1, v.d0};
        out_ready = v.ordy;
        #1;
        check($sformatf("vec%0d in_ready", idx), 32'(in_ready), 32'(v.exp_rdy));
        @(posedge clk);
        #1;
        check($sformatf("vec%0d out_valid", idx), 32'(out_valid), 32'(v.exp_ov));
        if (v.exp_ov) begin
            check($sformatf("vec%0d out_data", idx), 32'(out_data), 32'(v.exp_data));
            check($sformatf("vec%0d out_sel", idx), 32'(out_sel), 32'(v.exp_sel));
        end
    endtask

    initial begin
        // round robin, both valid: A0 B0 A1 B1
        vecs[0]  = '{2'b11, 8'hA0, 8'hB0, 1'b1, 2'b01, 1'b1, 8'hA0, 1'b0};
        vecs[1]  = '{2'b11, 8'hA1, 8'hB0, 1'b1, 2'b10, 1'b1, 8'hB0, 1'b1};
        vecs[2]  = '{2'b11, 8'hA1, 8'hB1, 1'b1, 2'b01, 1'b1, 8'hA1, 1'b0};
        vecs[3]  = '{2'b11, 8'hA2, 8'hB1, 1'b1, 2'b10, 1'b1, 8'hB1, 1'b1};
        // backpressure: 0x55 held for three stalled cycles, then 0x66 follows
        vecs[4]  = '{2'b01, 8'h55, 8'h00, 1'b1, 2'b01, 1'b1, 8'h55, 1'b0};
        vecs[5]  = '{2'b01, 8'h66, 8'h00, 1'b0, 2'b00, 1'b1, 8'h55, 1'b0};
        vecs[6]  = '{2'b01, 8'h66, 8'h00, 1'b0, 2'b00, 1'b1, 8'h55, 1'b0};
        vecs[7]  = '{2'b01, 8'h66, 8'h00, 1'b0, 2'b00, 1'b1, 8'h55, 1'b0};
        vecs[8]  = '{2'b01, 8'h66, 8'h00, 1'b1, 2'b01, 1'b1, 8'h66, 1'b0};
        vecs[9]  = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0};
        // single requester on ch1, no bubbles
        vecs[10] = '{2'b10, 8'h00, 8'h01, 1'b1, 2'b10, 1'b1, 8'h01, 1'b1};
        vecs[11] = '{2'b10, 8'h00, 8'h02, 1'b1, 2'b10, 1'b1, 8'h02, 1'b1};
        vecs[12] = '{2'b10, 8'h00, 8'h03, 1'b1, 2'b10, 1'b1, 8'h03, 1'b1};
        vecs[13] = '{2'b10, 8'h00, 8'h04, 1'b1, 2'b10, 1'b1, 8'h04, 1'b1};
        vecs[14] = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0};

        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
        in_last   = 2'b11;
`endif
        #3;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset out_sel", 32'(out_sel), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("idle%0d in_ready", c), 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("idle%0d out_valid", c), 32'(out_valid), 32'd0);
        end

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i], i);
        end

        // async reset mid-stream: ch0 was last accepted, so ch0 winning afterwards proves the pointer reset
        @(negedge clk);
        in_valid  = 2'b01;
        in_data   = {8'h00, 8'hC0};
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("pre-reset out_valid", 32'(out_valid), 32'd1);
        check("pre-reset out_data", 32'(out_data), 32'hC0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset out_data", 32'(out_data), 32'd0);
        check("async reset in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 2'b00;
        @(negedge clk);
        in_valid  = 2'b11;
        in_data   = {8'hD1, 8'hC1};
        out_ready = 1'b1;
        #1;
        check("post-reset in_ready", 32'(in_ready), 32'b01);
        @(posedge clk);
        #1;
        check("post-reset out_data", 32'(out_data), 32'hC1);
        check("post-reset out_sel", 32'(out_sel), 32'd0);

`ifdef STREAM_MUX_PKT_LOCK_EN
        // single-word packet on ch1 leaves the arbiter free and moves the pointer to ch1
        @(negedge clk);
        in_valid = 2'b10;
        in_data  = {8'hE0, 8'h00};
        in_last  = 2'b10;
        @(posedge clk);
        #1;
        check("single pkt out_sel", 32'(out_sel), 32'd1);
        check("single pkt out_last", 32'(out_last), 32'd1);
        // ch0 3-word packet while ch1 stays valid: sel 0,0,0 then 1
        for (int w = 0; w < 4; w++) begin
            logic [7:0] exp_d;
            logic       exp_s;
            logic       exp_l;
            @(negedge clk);
            in_valid = 2'b11;
            in_data  = {8'hE1, 8'(8'h10 + w)};
            in_last  = {1'b1, (w == 2)};
            exp_d    = (w < 3) ? 8'(8'h10 + w) : 8'hE1;
            exp_s    = (w == 3);
            exp_l    = (w >= 2);
            @(posedge clk);
            #1;
            check($sformatf("pkt%0d out_sel", w), 32'(out_sel), 32'(exp_s));
            check($sformatf("pkt%0d out_data", w), 32'(out_data), 32'(exp_d));
            check($sformatf("pkt%0d out_last", w), 32'(out_last), 32'(exp_l));
        end
`endif

        @(negedge clk);
        in_valid = 2'b00;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
